// File: rtl/direction_queue_multi.sv
// direction_queue_multi
// Per-player snake steering. Raw active-low keys are synchronised, optionally
// debounced, turned into single-press turn requests, validated against the
// last committed heading, buffered in a small FIFO and applied one per step.
// Optional feature: define DIR_DEBOUNCE_EN to keep the per-key debounce
// counters; without it the debounced state is the synchronised key value.
module direction_queue_multi #(
  parameter int NUM_PLAYERS     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int QUEUE_DEPTH     = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [4*NUM_PLAYERS-1:0] keysHW,
  input  logic                     step,
  output logic [4*NUM_PLAYERS-1:0] direction,
  output logic [NUM_PLAYERS-1:0]   queueFull,
  output logic [NUM_PLAYERS-1:0]   dropped
);

  localparam int KEYS  = 4 * NUM_PLAYERS;
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CW    = PTR_W + 1;

  if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
    $error("direction_queue_multi: QUEUE_DEPTH must be a power of 2 >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  logic [KEYS-1:0] sync1, sync2;
  logic [KEYS-1:0] debounced;

  // Two-flop synchroniser; idle (released) level is 1
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= keysHW;
      sync2 <= sync1;
    end
  end

`ifdef DIR_DEBOUNCE_EN
  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt [KEYS];

  // Per-key debounce: the state follows the synced key only after it has differed for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clock) begin
    if (!reset) begin
      debounced <= '1;
      for (int i = 0; i < KEYS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < KEYS; i++) begin
        if (sync2[i] == debounced[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          debounced[i] <= sync2[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  assign debounced = sync2;
`endif

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [3:0]       pressed, pressed_q;
    logic [3:0]       dir_q, tail, ref_dir, rev_ref;
    logic [3:0]       mem [QUEUE_DEPTH];
    logic [CW-1:0]    wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx, count_nx;
    logic [PTR_W-1:0] tail_idx;
    logic             fifo_empty, fifo_full, press_evt, accept, do_push, do_pop;
    logic             full_q, drop_q;

    // A press is a change of the held-key vector to exactly one key
    assign pressed   = ~debounced[4*p +: 4];
    assign press_evt = (pressed != pressed_q) && (pressed != 4'd0) &&
                       ((pressed & (pressed - 4'd1)) == 4'd0);

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    // Validate against the newest queued turn, or the live heading when nothing is queued
    assign tail_idx = wr_ptr[PTR_W-1:0] - PTR_W'(1);
    assign tail     = mem[tail_idx];
    assign ref_dir  = fifo_empty ? dir_q : tail;
    assign rev_ref  = {ref_dir[2], ref_dir[3], ref_dir[0], ref_dir[1]};
    assign accept   = press_evt && (pressed != ref_dir) && (pressed != rev_ref);
    assign do_push  = accept && !fifo_full;
    assign do_pop   = step && !fifo_empty;

    // Next-state for the FIFO pointers
    always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      wr_ptr_nx = wr_ptr;
      rd_ptr_nx = rd_ptr;
      if (do_push) wr_ptr_nx = wr_ptr + CW'(1);
      if (do_pop)  rd_ptr_nx = rd_ptr + CW'(1);
    end

    assign count_nx = wr_ptr_nx - rd_ptr_nx;

    // Pointers, heading, edge-detect history and registered status flags
    always_ff @(posedge clock) begin
      if (!reset) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        dir_q     <= 4'd0;
        pressed_q <= 4'd0;
        full_q    <= 1'b0;
        drop_q    <= 1'b0;
      end else begin
        wr_ptr    <= wr_ptr_nx;
        rd_ptr    <= rd_ptr_nx;
        pressed_q <= pressed;
        full_q    <= (count_nx == CW'(QUEUE_DEPTH));
        drop_q    <= accept && fifo_full;
        if (do_pop) dir_q <= mem[rd_ptr[PTR_W-1:0]];
      end
    end

    // Turn storage written on accepted pushes
    always_ff @(posedge clock) begin
      // NOTE: storage has no reset; the pointers define which entries are live, so stale contents are never read.
      if (do_push) mem[wr_ptr[PTR_W-1:0]] <= pressed;
    end

    assign direction[4*p +: 4] = dir_q;
    assign queueFull[p]        = full_q;
    assign dropped[p]          = drop_q;
  end

endmodule

// File: tb/tb_direction_queue_multi.sv
// Testbench for direction_queue_multi: directed vector table, hand-written
// corner sequences and randomized key/step/reset traffic checked every cycle
// against a behavioural model (history windows + array FIFO).
module tb_direction_queue_multi;

  localparam int NP = 2;
  localparam int D  = 4;
  localparam int QD = 4;
`ifdef DIR_DEBOUNCE_EN
  localparam int LAT = 2 + D;
`else
  localparam int LAT = 2;
`endif
  localparam int H = LAT + 3;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [4*NP-1:0] keysHW = '1;
  logic            step = 1'b0;
  logic [4*NP-1:0] direction;
  logic [NP-1:0]   queueFull;
  logic [NP-1:0]   dropped;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  direction_queue_multi #(
    .NUM_PLAYERS(NP), .DEBOUNCE_CYCLES(D), .QUEUE_DEPTH(QD)
  ) dut (
    .clock(clock), .reset(reset), .keysHW(keysHW), .step(step),
    .direction(direction), .queueFull(queueFull), .dropped(dropped)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [3:0] rev4(input logic [3:0] d);
    case (d)
      4'b0001: return 4'b0010;
      4'b0010: return 4'b0001;
      4'b0100: return 4'b1000;
      4'b1000: return 4'b0100;
      default: return 4'b0000;
    endcase
  endfunction

  logic [4*NP-1:0] m_s1 = '1, m_s2 = '1, m_deb = '1, m_deb_prev = '1;
  logic [4*NP-1:0] win [D];
  int              win_n = 0;
  logic [3:0]      m_fifo [NP][QD];
  int              m_cnt [NP];
  logic [3:0]      m_dir [NP];
  logic            m_full [NP];
  logic            m_drop [NP];

  always @(posedge clock) begin : model
    logic [3:0] pr, pv, r;
    bit ev, acc, was_full, all_diff;
    if (!reset) begin
      m_s1 = '1; m_s2 = '1; m_deb = '1; m_deb_prev = '1; win_n = 0;
      for (int p = 0; p < NP; p++) begin
        m_cnt[p] = 0; m_dir[p] = 4'd0; m_full[p] = 1'b0; m_drop[p] = 1'b0;
      end
    end else begin
      for (int p = 0; p < NP; p++) begin
        pr = ~m_deb[4*p +: 4];
        pv = ~m_deb_prev[4*p +: 4];
        ev = (pr != pv) && ($countones(pr) == 1);
        r  = (m_cnt[p] > 0) ? m_fifo[p][m_cnt[p]-1] : m_dir[p];
        acc = ev && (pr != r) && (pr != rev4(r));
        was_full = (m_cnt[p] == QD);
        m_drop[p] = acc && was_full;
        if (step && m_cnt[p] > 0) begin
          m_dir[p] = m_fifo[p][0];
          for (int i = 0; i < QD - 1; i++) m_fifo[p][i] = m_fifo[p][i+1];
          m_cnt[p]--;
        end
        if (acc && !was_full) begin
          m_fifo[p][m_cnt[p]] = pr;
          m_cnt[p]++;
        end
        m_full[p] = (m_cnt[p] == QD);
      end
      m_deb_prev = m_deb;
`ifdef DIR_DEBOUNCE_EN
      // a key changes state once its synced level has differed for the last D cycles
      for (int i = 0; i < D - 1; i++) win[i] = win[i+1];
      win[D-1] = m_s2;
      if (win_n < D) win_n++;
      if (win_n == D) begin
        for (int b = 0; b < 4*NP; b++) begin
          all_diff = 1'b1;
          for (int i = 0; i < D; i++) if (win[i][b] == m_deb[b]) all_diff = 1'b0;
          if (all_diff) m_deb[b] = ~m_deb[b];
        end
      end
`else
      m_deb = m_s1;
`endif
      m_s2 = m_s1;
      m_s1 = keysHW;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clock) begin
    if (mon_en) begin
      for (int p = 0; p < NP; p++) begin
        check($sformatf("model dir p%0d", p), 32'(direction[4*p +: 4]), 32'(m_dir[p]));
        check($sformatf("model full p%0d", p), 32'(queueFull[p]), 32'(m_full[p]));
        check($sformatf("model drop p%0d", p), 32'(dropped[p]), 32'(m_drop[p]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic hold_keys(input logic [4*NP-1:0] k, input int n);
    keysHW = k;
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clock);
    step = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  typedef struct {
    string           name;
    logic [4*NP-1:0] keys;
    bit              do_step;
    logic [4*NP-1:0] exp_dir;
    logic [NP-1:0]   exp_full;
  } vec_t;

  vec_t vecs [15];
  int   drops;
  int   hold [NP];
  logic [3:0] cur [NP];

  initial begin
    vecs[0]  = '{"down",            8'hFE, 1, 8'h01, 2'b00};
    vecs[1]  = '{"rel1",            8'hFF, 0, 8'h01, 2'b00};
    vecs[2]  = '{"up reversal",     8'hFD, 0, 8'h01, 2'b00};
    vecs[3]  = '{"rel2",            8'hFF, 0, 8'h01, 2'b00};
    vecs[4]  = '{"same dir",        8'hFE, 1, 8'h01, 2'b00};
    vecs[5]  = '{"rel3",            8'hFF, 0, 8'h01, 2'b00};
    vecs[6]  = '{"right",           8'hFB, 1, 8'h04, 2'b00};
    vecs[7]  = '{"rel4",            8'hFF, 0, 8'h04, 2'b00};
    vecs[8]  = '{"p1 left p0 multi",8'h7C, 1, 8'h84, 2'b00};
    vecs[9]  = '{"p0 all held",     8'h70, 1, 8'h84, 2'b00};
    vecs[10] = '{"rel5",            8'hFF, 0, 8'h84, 2'b00};
    vecs[11] = '{"p1 down",         8'hEF, 1, 8'h14, 2'b00};
    vecs[12] = '{"rel6",            8'hFF, 0, 8'h14, 2'b00};
    vecs[13] = '{"p0 up",           8'hFD, 1, 8'h12, 2'b00};
    vecs[14] = '{"rel7",            8'hFF, 0, 8'h12, 2'b00};

    // Reset state
    reset = 1'b0; keysHW = '1; step = 1'b0;
    repeat (2) @(negedge clock);
    check("reset dir", 32'(direction), 32'h0);
    check("reset full", 32'(queueFull), 32'h0);
    check("reset drop", 32'(dropped), 32'h0);
    mon_en = 1'b1;
    reset = 1'b1;

    // Latency and no-bypass: step held high, push lands at edge k+LAT, applied at k+LAT+1
    keysHW = 8'hFE; step = 1'b1;
    repeat (LAT + 1) @(negedge clock);
    check("latency before apply", 32'(direction[3:0]), 32'h0);
    @(negedge clock);
    check("latency applied", 32'(direction[3:0]), 32'h1);
    step = 1'b0;
    hold_keys(8'hFF, H);

    // Short pulse: filtered with debounce, accepted without it
    do_reset();
`ifdef DIR_DEBOUNCE_EN
    hold_keys(8'hFB, 3);
    hold_keys(8'hFF, H);
    pulse_step();
    check("short pulse ignored", 32'(direction[3:0]), 32'h0);
`else
    hold_keys(8'hFB, 1);
    hold_keys(8'hFF, H);
    pulse_step();
    check("glitch accepted", 32'(direction[3:0]), 32'h4);
`endif

    // Directed table
    do_reset();
    @(negedge clock);
    foreach (vecs[i]) begin
      hold_keys(vecs[i].keys, H);
      if (vecs[i].do_step) pulse_step();
      check({"vec ", vecs[i].name, " dir"}, 32'(direction), 32'(vecs[i].exp_dir));
      check({"vec ", vecs[i].name, " full"}, 32'(queueFull), 32'(vecs[i].exp_full));
    end

    // Fill to full, drop one, drain in order
    do_reset();
    hold_keys(8'hFB, H); hold_keys(8'hFF, H);
    hold_keys(8'hFD, H); hold_keys(8'hFF, H);
    hold_keys(8'hF7, H); hold_keys(8'hFF, H);
    hold_keys(8'hFE, H);
    check("full after 4", 32'(queueFull[0]), 32'h1);
    hold_keys(8'hFF, H);
    keysHW = 8'hFB;
    drops = 0;
    repeat (H) begin
      @(negedge clock);
      if (dropped[0]) drops++;
    end
    check("drop pulse count", 32'(drops), 32'h1);
    check("still full", 32'(queueFull[0]), 32'h1);
    hold_keys(8'hFF, H);
    pulse_step(); check("drain 1", 32'(direction[3:0]), 32'h4);
    check("not full after pop", 32'(queueFull[0]), 32'h0);
    pulse_step(); check("drain 2", 32'(direction[3:0]), 32'h2);
    pulse_step(); check("drain 3", 32'(direction[3:0]), 32'h8);
    pulse_step(); check("drain 4", 32'(direction[3:0]), 32'h1);

    // Push and pop on the same edge, then reset mid-queue
    do_reset();
    hold_keys(8'hFB, H); hold_keys(8'hFF, H);
    hold_keys(8'hFD, H); hold_keys(8'hFF, H);
    keysHW = 8'hF7;
    repeat (LAT) @(negedge clock);
    pulse_step();
    check("same-edge pop", 32'(direction[3:0]), 32'h4);
    hold_keys(8'hFF, H);
    pulse_step(); check("same-edge order 2", 32'(direction[3:0]), 32'h2);
    pulse_step(); check("same-edge order 3", 32'(direction[3:0]), 32'h8);
    pulse_step(); check("empty step holds", 32'(direction[3:0]), 32'h8);
    hold_keys(8'hFE, H); hold_keys(8'hFF, H);
    hold_keys(8'hFB, H); hold_keys(8'hFF, H);
    do_reset();
    check("mid reset dir", 32'(direction), 32'h0);
    check("mid reset full", 32'(queueFull), 32'h0);
    pulse_step(); pulse_step();
    check("steps after reset", 32'(direction), 32'h0);

    // Randomized traffic, checked by the model monitor
    for (int p = 0; p < NP; p++) begin hold[p] = 0; cur[p] = 4'hF; end
    repeat (3000) begin
      for (int p = 0; p < NP; p++) begin
        if (hold[p] == 0) begin
          int r;
          r = $urandom_range(0, 99);
          if (r < 55)      cur[p] = ~(4'(4'b0001 << $urandom_range(0, 3)));
          else if (r < 85) cur[p] = 4'hF;
          else             cur[p] = 4'($urandom);
          hold[p] = $urandom_range(1, LAT + 5);
        end
        hold[p]--;
        keysHW[4*p +: 4] = cur[p];
      end
      step  = ($urandom_range(0, 4) == 0);
      reset = ($urandom_range(0, 299) != 0);
      @(negedge clock);
    end
    reset = 1'b1; step = 1'b0; keysHW = '1;
    @(negedge clock);
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
